lg_reduce_pipe: RTL and testbench
=================================

// Module: lg_reduce_pipe
// PURPOSE
//  Parametrised, registered N-input reduction gate unit; next generation of the fixed 2..5-input NOR gate cells.
//  Per transaction: selects an operation (AND/OR/NAND/NOR/XOR/XNOR), masks the participating inputs
//  and returns a 1-bit result over a valid/ready handshake (latency 1).
//  Also counts results equal to 1 and flags illegal op codes; sits between operand sources and result logging.
// PARAMETERS
//  WIDTH   6  number of gate inputs (in_data/in_mask width), >=2
//  CNT_W   8  width of saturating ones-result counter, >=1
// PORTS
//  clk         in   1        rising-edge clock
//  rst_n       in   1        asynchronous active-low reset
//  in_valid    in   1        operand transaction valid
//  in_ready    out  1        unit can accept operand this cycle
//  in_data     in   WIDTH    gate input bits
//  in_mask     in   WIDTH    1 = bit participates; 0 = bit ignored
//  in_op       in   3        0 AND,1 OR,2 NAND,3 NOR,4 XOR,5 XNOR,6/7 reserved
//  out_valid   out  1        result register holds unconsumed result
//  out_ready   in   1        downstream accepts result
//  out_y       out  1        gate result
//  out_err     out  1        result came from reserved op
//  cnt_clr     in   1        synchronous clear of ones_cnt
//  ones_cnt    out  CNT_W    count of delivered results with out_y=1 (saturating)
//  err_sticky  out  1        set on any accepted reserved op; cleared only by reset
// BEHAVIOUR
//  - Reset (async, rst_n=0): out_valid=0, out_y=0, out_err=0, ones_cnt=0, err_sticky=0; in_ready=1 after release.
//  - in_ready = !out_valid | out_ready (combinational). Accept = in_valid & in_ready.
//  - On accept: out_valid<=1 next edge; out_y/out_err loaded from the accepted operand. Latency 1 cycle.
//  - No accept & out_ready & out_valid: out_valid<=0; out_y/out_err hold their values.
//  - Simultaneous deliver+accept (out_valid&out_ready&accept): back-to-back, out_valid stays 1, new result loaded.
//  - out_y/out_err must not change while out_valid=1 & out_ready=0.
//  - Masked bits take the identity value: 1 for AND/NAND, 0 for OR/NOR/XOR/XNOR.
//    So in_mask=0 (empty) gives: AND 1, OR 0, NAND 0, NOR 1, XOR 0, XNOR 1.
//  - NAND/NOR/XNOR = inverse of AND/OR/XOR over the masked set.
//  - Reserved op (6/7): out_y=0, out_err=1; err_sticky<=1 on accept.
//  - Delivery = out_valid & out_ready. On delivery with out_y=1: ones_cnt += 1, saturating at 2^CNT_W-1.
//  - cnt_clr has priority over an increment in the same cycle: ones_cnt<=0.
//  - in_data/in_mask/in_op are sampled only on accept; values while in_valid=0 have no effect.
//  - Reset mid-transaction drops any pending result: out_valid=0 immediately; nothing is counted.
// TESTING (WIDTH=6, CNT_W=2 unless noted)
//  1. NOR 2..5 inputs: op=3, data=6'b000011, mask 6'b000011 / 000111 / 001111 / 011111 -> out_y=0 each;
//     data=0, mask=6'b011111 -> out_y=1.
//  2. Identity/mask: op=0 AND, data=6'b110000, mask=6'b110000 -> 1; same data, mask=6'b111111 -> 0;
//     mask=0 on each op -> 1,0,0,1,0,1.
//  3. Backpressure: accept XOR data=6'b000111 mask=all (y=1), hold out_ready=0 4 cycles
//     -> in_ready=0, out_y stable 1, ones_cnt=0; out_ready=1 -> ones_cnt=1.
//  4. Streaming: in_valid=out_ready=1 for 5 results all y=1 -> one result per cycle;
//     ones_cnt saturates at 3; cnt_clr with a delivery in the same cycle -> ones_cnt=0.
//  5. Reserved op=6, data=6'b111111 -> out_y=0, out_err=1, err_sticky=1; err_sticky stays 1 after later legal ops.
//  6. Reset mid-op: out_valid=1, out_ready=0, assert rst_n=0 between edges -> all outputs 0 immediately;
//     after release in_ready=1.

Source files
------------

// File: rtl/lg_reduce_pipe.sv
// Registered N-input reduction gate (AND/OR/NAND/NOR/XOR/XNOR) with masked inputs,
// valid/ready handshake, saturating ones-result counter and sticky reserved-op flag.
module lg_reduce_pipe #(
   parameter int unsigned WIDTH = 6,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [WIDTH-1:0] in_mask,
   input  logic [2:0]       in_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_y,
   output logic             out_err,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] ones_cnt,
   output logic             err_sticky
);

   localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

   logic             r_valid;
   logic             r_y;
   logic             r_err;
   logic [CNT_W-1:0] r_cnt;
   logic             r_sticky;

   logic w_accept;
   logic w_deliver;
   logic w_and;
   logic w_or;
   logic w_xor;
   logic w_y;
   logic w_err;

   assign in_ready  = !r_valid || out_ready;
   assign w_accept  = in_valid && in_ready;
   assign w_deliver = r_valid && out_ready;

   // Masked bits are forced to the identity of each reduction.
   assign w_and = &(in_data | ~in_mask);
   assign w_or  = |(in_data & in_mask);
   assign w_xor = ^(in_data & in_mask);

   always_comb begin
      w_y   = 1'b0;
      w_err = 1'b0;
      unique case (in_op)
         3'd0:    w_y = w_and;
         3'd1:    w_y = w_or;
         3'd2:    w_y = !w_and;
         3'd3:    w_y = !w_or;
         3'd4:    w_y = w_xor;
         3'd5:    w_y = !w_xor;
         default: w_err = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_y     <= 1'b0;
         r_err   <= 1'b0;
      end else if (w_accept) begin
         r_valid <= 1'b1;
         r_y     <= w_y;
         r_err   <= w_err;
      end else if (w_deliver) begin
         r_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (cnt_clr) begin
         r_cnt <= '0;
      end else if (w_deliver && r_y && (r_cnt != CntMax)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sticky <= 1'b0;
      end else if (w_accept && w_err) begin
         r_sticky <= 1'b1;
      end
   end

   assign out_valid  = r_valid;
   assign out_y      = r_y;
   assign out_err    = r_err;
   assign ones_cnt   = r_cnt;
   assign err_sticky = r_sticky;

endmodule

// File: tb/tb_lg_reduce_pipe.sv
// Scoreboard bench for lg_reduce_pipe (WIDTH=6, CNT_W=2): expected {y,err} queued on accept,
// checked on delivery; ones counter tracked by a small model.
module tb_lg_reduce_pipe;

   localparam int unsigned WIDTH = 6;
   localparam int unsigned CNT_W = 2;
   localparam int          CntMax = (1 << CNT_W) - 1;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [WIDTH-1:0] in_mask;
   logic [2:0]       in_op;
   logic             out_valid;
   logic             out_ready;
   logic             out_y;
   logic             out_err;
   logic             cnt_clr;
   logic [CNT_W-1:0] ones_cnt;
   logic             err_sticky;

   int         n_chk;
   int         n_fail;
   int         m_cnt;
   logic [1:0] sb[$];

   lg_reduce_pipe #(
      .WIDTH(WIDTH),
      .CNT_W(CNT_W)
   ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_mask   (in_mask),
      .in_op     (in_op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_y     (out_y),
      .out_err   (out_err),
      .cnt_clr   (cnt_clr),
      .ones_cnt  (ones_cnt),
      .err_sticky(err_sticky)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Reference: walk the bits, returns {y, err}.
   function automatic logic [1:0] model(input logic [2:0] op, input logic [WIDTH-1:0] data,
                                        input logic [WIDTH-1:0] mask);
      logic a = 1'b1;
      logic o = 1'b0;
      logic x = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         if (mask[i]) begin
            a = a & data[i];
            o = o | data[i];
            x = x ^ data[i];
         end
      end
      case (op)
         3'd0:    return {a, 1'b0};
         3'd1:    return {o, 1'b0};
         3'd2:    return {~a, 1'b0};
         3'd3:    return {~o, 1'b0};
         3'd4:    return {x, 1'b0};
         3'd5:    return {~x, 1'b0};
         default: return 2'b01;
      endcase
   endfunction

   task automatic send(input logic [2:0] op, input logic [WIDTH-1:0] data,
                       input logic [WIDTH-1:0] mask);
      int n = 0;
      in_valid = 1'b1;
      in_op    = op;
      in_data  = data;
      in_mask  = mask;
      @(negedge clk);
      while (!in_ready) begin
         n++;
         if (n > 50) begin
            check_eq("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
         end
         @(negedge clk);
      end
      sb.push_back(model(op, data, mask));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      logic [1:0] e;
      logic       got;
      got = 1'b0;
      e   = 2'b00;
      if (!rst_n) begin
         sb.delete();
         m_cnt = 0;
      end else begin
         check_eq("ones_cnt", 32'(ones_cnt), 32'(m_cnt));
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check_eq("unexpected_result", 1, 0);
            end else begin
               e   = sb.pop_front();
               got = 1'b1;
               check_eq("out_y", 32'(out_y), 32'(e[1]));
               check_eq("out_err", 32'(out_err), 32'(e[0]));
            end
         end
         if (cnt_clr) m_cnt = 0;
         else if (got && e[1] && m_cnt != CntMax) m_cnt++;
      end
   end

   initial begin
      n_chk     = 0;
      n_fail    = 0;
      m_cnt     = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_mask   = '0;
      in_op     = '0;
      out_ready = 1'b1;
      cnt_clr   = 1'b0;

      #12;
      check_eq("rst_out_valid", 32'(out_valid), 0);
      check_eq("rst_out_y", 32'(out_y), 0);
      check_eq("rst_out_err", 32'(out_err), 0);
      check_eq("rst_ones_cnt", 32'(ones_cnt), 0);
      check_eq("rst_err_sticky", 32'(err_sticky), 0);
      #10 rst_n = 1'b1;
      idle(1);
      check_eq("rst_in_ready", 32'(in_ready), 1);

      // NOR cells of 2..5 inputs.
      send(3'd3, 6'b000011, 6'b000011);
      send(3'd3, 6'b000011, 6'b000111);
      send(3'd3, 6'b000011, 6'b001111);
      send(3'd3, 6'b000011, 6'b011111);
      send(3'd3, 6'b000000, 6'b011111);
      // Identity of masked bits.
      send(3'd0, 6'b110000, 6'b110000);
      send(3'd0, 6'b110000, 6'b111111);
      for (int op = 0; op < 6; op++) send(3'(op), 6'b101101, 6'b000000);
      send(3'd4, 6'b010110, 6'b011110);
      send(3'd5, 6'b010110, 6'b011110);
      send(3'd2, 6'b111111, 6'b100001);
      send(3'd1, 6'b100000, 6'b011111);
      idle(2);

      // Reserved op.
      send(3'd6, 6'b111111, 6'b111111);
      check_eq("err_out_y", 32'(out_y), 0);
      check_eq("err_out_err", 32'(out_err), 1);
      check_eq("err_sticky_set", 32'(err_sticky), 1);
      send(3'd7, 6'b000000, 6'b000000);
      send(3'd1, 6'b000001, 6'b000001);
      idle(2);
      check_eq("err_sticky_hold", 32'(err_sticky), 1);

      // Backpressure.
      out_ready = 1'b0;
      cnt_clr   = 1'b1;
      idle(1);
      cnt_clr = 1'b0;
      send(3'd4, 6'b000111, 6'b111111);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_eq("bp_in_ready", 32'(in_ready), 0);
         check_eq("bp_out_y", 32'(out_y), 1);
         check_eq("bp_out_valid", 32'(out_valid), 1);
         check_eq("bp_ones_cnt", 32'(ones_cnt), 0);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      idle(1);
      check_eq("bp_ones_after", 32'(ones_cnt), 1);

      // Streaming with saturation.
      cnt_clr = 1'b1;
      idle(1);
      cnt_clr = 1'b0;
      for (int i = 0; i < 5; i++) begin
         send(3'd4, 6'(i + 1) | 6'b100000, 6'b100000);
         if (i > 0) check_eq("stream_valid", 32'(out_valid), 1);
      end
      idle(1);
      check_eq("sat_ones_cnt", 32'(ones_cnt), CntMax);
      send(3'd1, 6'b000001, 6'b000001);
      cnt_clr = 1'b1;
      idle(1);
      cnt_clr = 1'b0;
      check_eq("clr_prio_cnt", 32'(ones_cnt), 0);
      send(3'd0, 6'b111111, 6'b111111);
      idle(1);

      // Reset with a pending result.
      out_ready = 1'b0;
      send(3'd5, 6'b000011, 6'b000011);
      check_eq("pend_valid", 32'(out_valid), 1);
      check_eq("pend_y", 32'(out_y), 1);
      #2 rst_n = 1'b0;
      #1;
      check_eq("mid_rst_valid", 32'(out_valid), 0);
      check_eq("mid_rst_y", 32'(out_y), 0);
      check_eq("mid_rst_err", 32'(out_err), 0);
      check_eq("mid_rst_cnt", 32'(ones_cnt), 0);
      check_eq("mid_rst_sticky", 32'(err_sticky), 0);
      idle(1);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      #1;
      check_eq("post_rst_in_ready", 32'(in_ready), 1);
      send(3'd3, 6'b000000, 6'b000011);
      idle(3);
      check_eq("sb_drained", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
